// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: substate codes, training-set constants, field positions,
// the per-lane checker state type and the per-substate match predicate.
package ltssm_pkg;

    localparam logic [3:0] SS_DETECT_QUIET     = 4'd0;
    localparam logic [3:0] SS_DETECT_ACTIVE    = 4'd1;
    localparam logic [3:0] SS_POLLING_ACTIVE   = 4'd2;
    localparam logic [3:0] SS_POLLING_CONFIG   = 4'd3;
    localparam logic [3:0] SS_CFG_LW_START     = 4'd4;
    localparam logic [3:0] SS_CFG_LW_ACCEPT    = 4'd5;
    localparam logic [3:0] SS_CFG_LN_WAIT      = 4'd6;
    localparam logic [3:0] SS_CFG_LN_ACCEPT    = 4'd7;
    localparam logic [3:0] SS_CFG_COMPLETE     = 4'd8;
    localparam logic [3:0] SS_CFG_IDLE         = 4'd9;
    localparam logic [3:0] SS_L0               = 4'd10;

    localparam logic [7:0] PAD = 8'hF7;
    localparam logic [7:0] TS1 = 8'h2A;
    localparam logic [7:0] TS2 = 8'h45;

    localparam int LINK_LSB  = 8;
    localparam int LANE_LSB  = 16;
    localparam int RATE_LSB  = 32;
    localparam int UPCFG_BIT = 42;
    localparam int B43_BIT   = 43;
    localparam int ID_LSB    = 80;

    typedef enum logic [1:0] {
        LANE_IDLE  = 2'd0,
        LANE_HUNT  = 2'd1,
        LANE_COUNT = 2'd2,
        LANE_DONE  = 2'd3
    } lane_state_e;

    function automatic logic ss_defined(input logic [3:0] ss);
        return (ss >= SS_POLLING_ACTIVE) && (ss <= SS_CFG_COMPLETE);
    endfunction

    function automatic logic ts_match(
        input logic [7:0] link,
        input logic [7:0] lane,
        input logic [7:0] id,
        input logic       b42,
        input logic       b43,
        input logic [3:0] ss,
        input logic [7:0] link_num,
        input logic [7:0] exp_lane,
        input logic       upstream
    );
        logic is_ts1;
        logic is_ts2;
        logic pad_pad;
        logic num_ok;
        is_ts1  = (id == TS1);
        is_ts2  = (id == TS2);
        pad_pad = (link == PAD) && (lane == PAD);
        num_ok  = (link == link_num) && (lane == exp_lane);
        case (ss)
            SS_POLLING_ACTIVE: ts_match = pad_pad && ((is_ts1 && (!b43 || b42)) || is_ts2);
            SS_POLLING_CONFIG: ts_match = pad_pad && is_ts2;
            SS_CFG_LW_START:   ts_match = is_ts1 && (lane == PAD) &&
                                          (upstream ? (link != PAD) : (link == link_num));
            SS_CFG_LW_ACCEPT:  ts_match = is_ts1 && (link == link_num) && (lane != PAD);
            SS_CFG_LN_WAIT,
            SS_CFG_LN_ACCEPT:  ts_match = num_ok && (upstream ? is_ts2 : is_ts1);
            SS_CFG_COMPLETE:   ts_match = num_ok && is_ts2;
            default:           ts_match = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ts_lane_checker.sv
// One lane of the consecutive training-set checker: IDLE/HUNT/COUNT/DONE counter.
// Optional TS_CONSIST_CHK_EN adds rate-id/upconfigure consistency in configurationComplete.
module ts_lane_checker
    import ltssm_pkg::*;
#(
    parameter int DEVICETYPE = 0,
    parameter int THRESH     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] os,
    input  logic         valid,
    input  logic [3:0]   substate,
    input  logic         sub_change,
    input  logic [7:0]   link_number,
    input  logic [7:0]   exp_lane,
    output logic         match,
    output logic [7:0]   count,
    output logic         done,
    output logic         done_next
);

    localparam logic [7:0] THRESH_C = 8'(THRESH);

    lane_state_e state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic        done_q;
    logic        inconsistent;
    logic        unused_os;

    assign unused_os = ^os;

    assign match = ts_match(os[LINK_LSB +: 8], os[LANE_LSB +: 8], os[ID_LSB +: 8],
                            os[UPCFG_BIT], os[B43_BIT], substate, link_number,
                            exp_lane, DEVICETYPE != 0);

`ifdef TS_CONSIST_CHK_EN
    logic [7:0] prev_rate_q, prev_rate_d;
    logic       prev_upcfg_q, prev_upcfg_d;

    always_comb begin
        prev_rate_d  = valid ? os[RATE_LSB +: 8] : prev_rate_q;
        prev_upcfg_d = valid ? os[UPCFG_BIT]     : prev_upcfg_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_rate_q  <= 8'h00;
            prev_upcfg_q <= 1'b0;
        end else begin
            prev_rate_q  <= prev_rate_d;
            prev_upcfg_q <= prev_upcfg_d;
        end
    end

    assign inconsistent = (substate == SS_CFG_COMPLETE) &&
                          ((os[RATE_LSB +: 8] != prev_rate_q) || (os[UPCFG_BIT] != prev_upcfg_q));
`else
    assign inconsistent = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        // A substate change wins over anything the lane would otherwise do this cycle.
        if (sub_change) begin
            state_d = LANE_IDLE;
            count_d = 8'd0;
        end else begin
            case (state_q)
                LANE_IDLE: begin
                    if (ss_defined(substate)) state_d = LANE_HUNT;
                end
                LANE_HUNT: begin
                    if (valid && match) begin
                        state_d = LANE_COUNT;
                        count_d = 8'd1;
                    end
                end
                LANE_COUNT: begin
                    if (valid && match && inconsistent) begin
                        state_d = LANE_HUNT;
                        count_d = 8'd1;
                    end else if (valid && match) begin
                        count_d = count_q + 8'd1;
                        if (count_q + 8'd1 == THRESH_C) state_d = LANE_DONE;
                    end else if (valid) begin
                        state_d = LANE_HUNT;
                        count_d = 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done_next = (state_d == LANE_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LANE_IDLE;
            count_q <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_next;
        end
    end

    assign count = count_q;
    assign done  = done_q;

endmodule

// File: rtl/ts_consec_checker.sv
// Multi-lane consecutive training-set checker with all-lanes aggregation and lane-0 rate capture.
// Build option: define TS_CONSIST_CHK_EN to enable per-lane rate/upconfigure consistency checking.
module ts_consec_checker
    import ltssm_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DEVICETYPE = 0,
    parameter int THRESH     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LANES*128-1:0] orderedset,
    input  logic [LANES-1:0]     valid,
    input  logic [3:0]           substate,
    input  logic [7:0]           linkNumber,
    input  logic [7:0]           laneBase,
    input  logic [LANES-1:0]     laneMask,
    output logic [LANES*8-1:0]   laneCount,
    output logic [LANES-1:0]     laneDone,
    output logic                 allDone,
    output logic [7:0]           rateid,
    output logic                 upconfigure_capability
);

    logic [3:0]       substate_q;
    logic             sub_change;
    logic [LANES-1:0] lane_match;
    logic [LANES-1:0] lane_done_next;
    logic             all_done_q, all_done_d;
    logic [7:0]       rateid_q, rateid_d;
    logic             upcfg_q, upcfg_d;

    assign sub_change = (substate != substate_q);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            ts_lane_checker #(
                .DEVICETYPE (DEVICETYPE),
                .THRESH     (THRESH)
            ) u_lane (
                .clk         (clk),
                .reset       (reset),
                .os          (orderedset[128*gi +: 128]),
                .valid       (valid[gi]),
                .substate    (substate),
                .sub_change  (sub_change),
                .link_number (linkNumber),
                .exp_lane    (laneBase + 8'(gi)),
                .match       (lane_match[gi]),
                .count       (laneCount[8*gi +: 8]),
                .done        (laneDone[gi]),
                .done_next   (lane_done_next[gi])
            );
        end
    endgenerate

    // Aggregate from next-state so allDone lines up with the per-lane done flags.
    always_comb begin
        all_done_d = (laneMask != '0) && (&(lane_done_next | ~laneMask));
        rateid_d   = rateid_q;
        upcfg_d    = upcfg_q;
        if (valid[0] && lane_match[0]) begin
            rateid_d = orderedset[RATE_LSB +: 8];
            upcfg_d  = orderedset[UPCFG_BIT];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            substate_q <= SS_DETECT_QUIET;
            all_done_q <= 1'b0;
            rateid_q   <= 8'h00;
            upcfg_q    <= 1'b0;
        end else begin
            substate_q <= substate;
            all_done_q <= all_done_d;
            rateid_q   <= rateid_d;
            upcfg_q    <= upcfg_d;
        end
    end

    assign allDone                = all_done_q;
    assign rateid                 = rateid_q;
    assign upconfigure_capability = upcfg_q;

endmodule

// File: tb/tb_ts_consec_checker.sv
// Directed bench for ts_consec_checker (LANES=4, DEVICETYPE=0, THRESH=8).
module tb_ts_consec_checker;
    import ltssm_pkg::*;

    localparam int LANES = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [LANES*128-1:0] orderedset = '0;
    logic [LANES-1:0]     valid = '0;
    logic [3:0]           substate = SS_DETECT_QUIET;
    logic [7:0]           linkNumber = 8'h05;
    logic [7:0]           laneBase = 8'h02;
    logic [LANES-1:0]     laneMask = 4'hF;
    logic [LANES*8-1:0]   laneCount;
    logic [LANES-1:0]     laneDone;
    logic                 allDone;
    logic [7:0]           rateid;
    logic                 upconfigure_capability;

    int n_checks = 0;
    int n_err = 0;

    ts_consec_checker #(.LANES(LANES), .DEVICETYPE(0), .THRESH(8)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .orderedset             (orderedset),
        .valid                  (valid),
        .substate               (substate),
        .linkNumber             (linkNumber),
        .laneBase               (laneBase),
        .laneMask               (laneMask),
        .laneCount              (laneCount),
        .laneDone               (laneDone),
        .allDone                (allDone),
        .rateid                 (rateid),
        .upconfigure_capability (upconfigure_capability)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid = '0;
        repeat (n) step();
    endtask

    task automatic set_ss(input logic [3:0] ss);
        substate = ss;
        idle(2);
    endtask

    // lanes_b holds the lane-number byte per lane, lane 0 in the low byte.
    task automatic send(input logic [7:0] id, input logic [7:0] link, input logic [31:0] lanes_b,
                        input logic [7:0] rate, input logic b42, input logic b43);
        for (int i = 0; i < LANES; i++) begin
            logic [127:0] os;
            os = '0;
            os[15:8]  = link;
            os[23:16] = lanes_b[8*i +: 8];
            os[39:32] = rate;
            os[42]    = b42;
            os[43]    = b43;
            os[87:80] = id;
            orderedset[128*i +: 128] = os;
        end
        valid = 4'hF;
        step();
    endtask

    localparam logic [31:0] PADS  = {4{8'hF7}};
    localparam logic [31:0] GOOD  = {8'h05, 8'h04, 8'h03, 8'h02};
    localparam logic [31:0] BAD3  = {8'h04, 8'h04, 8'h03, 8'h02};

    initial begin
        logic [7:0] kb;
        logic [7:0] exp_cc;

        // Reset state
        #12;
        check("rst_count", laneCount, 32'h0);
        check("rst_done", {28'h0, laneDone}, 32'h0);
        check("rst_all", {31'h0, allDone}, 32'h0);
        check("rst_rate", {24'h0, rateid}, 32'h0);
        check("rst_upcfg", {31'h0, upconfigure_capability}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // pollingActive: 8 consecutive PAD/PAD/TS1 sets on all lanes
        set_ss(SS_POLLING_ACTIVE);
        for (int k = 1; k <= 8; k++) begin
            send(TS1, PAD, PADS, 8'h1F, 1'b1, 1'b0);
            kb = 8'(k);
            check("pa_count", laneCount, {4{kb}});
            if (k == 7) check("pa_all7", {31'h0, allDone}, 32'h0);
        end
        check("pa_done", {28'h0, laneDone}, 32'hF);
        check("pa_all", {31'h0, allDone}, 32'h1);
        check("pa_rate", {24'h0, rateid}, 32'h1F);
        check("pa_upcfg", {31'h0, upconfigure_capability}, 32'h1);
        // Non-matching set (TS1, bit43=1, bit42=0) in DONE: nothing clears, capture holds
        send(TS1, PAD, PADS, 8'h33, 1'b0, 1'b1);
        check("pa_hold_cnt", laneCount, {4{8'd8}});
        check("pa_hold_done", {28'h0, laneDone}, 32'hF);
        check("pa_hold_rate", {24'h0, rateid}, 32'h1F);
        check("pa_hold_upc", {31'h0, upconfigure_capability}, 32'h1);

        // configurationLanenumWait: lane 3 receives wrong lane number
        set_ss(SS_CFG_LN_WAIT);
        check("lw_idle_cnt", laneCount, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            send(TS1, 8'h05, BAD3, 8'h08, 1'b0, 1'b0);
            kb = 8'(k);
            check("lw_count", laneCount, {8'h00, kb, kb, kb});
        end
        check("lw_done", {28'h0, laneDone}, 32'h7);
        check("lw_all", {31'h0, allDone}, 32'h0);
        check("lw_rate", {24'h0, rateid}, 32'h08);
        check("lw_upcfg", {31'h0, upconfigure_capability}, 32'h0);
        laneMask = 4'h7;
        idle(1);
        check("mask7_all", {31'h0, allDone}, 32'h1);
        laneMask = 4'h0;
        idle(1);
        check("mask0_all", {31'h0, allDone}, 32'h0);
        laneMask = 4'hF;
        idle(1);
        check("maskF_all", {31'h0, allDone}, 32'h0);

        // configurationComplete: 5 matches, 1 mismatch, 8 matches
        set_ss(SS_CFG_COMPLETE);
        for (int k = 1; k <= 5; k++) begin
            send(TS2, 8'h05, GOOD, 8'h02, 1'b0, 1'b0);
            kb = 8'(k);
            check("cc_run1", laneCount, {4{kb}});
        end
        send(TS1, 8'h05, GOOD, 8'h02, 1'b0, 1'b0);
        check("cc_miss", laneCount, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            send(TS2, 8'h05, GOOD, 8'h02, 1'b0, 1'b0);
            kb = 8'(k);
            check("cc_run2", laneCount, {4{kb}});
            if (k == 7) check("cc_done7", {28'h0, laneDone}, 32'h0);
        end
        check("cc_done", {28'h0, laneDone}, 32'hF);
        check("cc_all", {31'h0, allDone}, 32'h1);

        // Substate change at count=6 with a simultaneous match
        set_ss(SS_CFG_LN_ACCEPT);
        check("chg_idle_dn", {28'h0, laneDone}, 32'h0);
        for (int k = 1; k <= 6; k++) send(TS1, 8'h05, GOOD, 8'h02, 1'b0, 1'b0);
        check("chg_cnt6", laneCount, {4{8'd6}});
        substate = SS_CFG_LN_WAIT;
        send(TS1, 8'h05, GOOD, 8'h02, 1'b0, 1'b0);
        check("chg_cnt0", laneCount, 32'h0);
        send(TS1, 8'h05, GOOD, 8'h02, 1'b0, 1'b0);
        check("chg_idle", laneCount, 32'h0);
        send(TS1, 8'h05, GOOD, 8'h02, 1'b0, 1'b0);
        check("chg_hunt", laneCount, {4{8'd1}});
        idle(2);
        check("cnt_hold", laneCount, {4{8'd1}});

        // configurationComplete rate-id change on set 4
        set_ss(SS_CFG_COMPLETE);
        for (int k = 1; k <= 3; k++) send(TS2, 8'h05, GOOD, 8'h02, 1'b0, 1'b0);
        check("cons_cnt3", laneCount, {4{8'd3}});
        send(TS2, 8'h05, GOOD, 8'h04, 1'b0, 1'b0);
`ifdef TS_CONSIST_CHK_EN
        exp_cc = 8'd1;
`else
        exp_cc = 8'd4;
`endif
        check("cons_cnt4", laneCount, {4{exp_cc}});
        check("cons_rate", {24'h0, rateid}, 32'h04);
        send(TS2, 8'h05, GOOD, 8'h04, 1'b0, 1'b0);
        check("cons_cnt5", laneCount, {4{exp_cc == 8'd1 ? 8'd1 : 8'd5}});

        // Asynchronous reset mid-COUNT
        #2;
        reset = 1'b0;
        #1;
        check("arst_count", laneCount, 32'h0);
        check("arst_done", {28'h0, laneDone}, 32'h0);
        check("arst_all", {31'h0, allDone}, 32'h0);
        check("arst_rate", {24'h0, rateid}, 32'h0);
        check("arst_upcfg", {31'h0, upconfigure_capability}, 32'h0);
        reset = 1'b1;
        idle(2);
        send(TS2, 8'h05, GOOD, 8'h04, 1'b0, 1'b0);
        check("resume_cnt", laneCount, {4{8'd1}});
        check("resume_rate", {24'h0, rateid}, 32'h04);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ts_consec_checker.md
TS_CONSEC_CHECKER -- requirements
Module: ts_consec_checker

Interface
REQ-001 SHALL have parameter LANES, default 4: number of receive lanes checked in parallel (1..16).
REQ-002 SHALL have parameter DEVICETYPE, default 0: 0 = downstream port, 1 = upstream port.
REQ-003 SHALL have parameter THRESH, default 8: number of consecutive matching ordered sets required per lane (2..255).
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port orderedset, input, LANES*128: per-lane 128-bit ordered set; lane i occupies bits [128*i+127 : 128*i].
REQ-007 SHALL have port valid, input, LANES: per-lane strobe meaning the lane's ordered set is present this cycle.
REQ-008 SHALL have port substate, input, 4: LTSSM substate code from the main LTSSM.
REQ-009 SHALL have port linkNumber, input, 8: expected link number.
REQ-010 SHALL have port laneBase, input, 8: expected lane number of lane 0; lane i expects laneBase+i, modulo 256.
REQ-011 SHALL have port laneMask, input, LANES: lanes taking part in the all-lanes condition.
REQ-012 SHALL have port laneCount, output, LANES*8: per-lane consecutive-match count.
REQ-013 SHALL have port laneDone, output, LANES: per-lane count has reached THRESH.
REQ-014 SHALL have port allDone, output, 1: every lane with laneMask=1 is done, and laneMask is not zero.
REQ-015 SHALL have port rateid, output, 8: rate identifier byte [39:32] from the last valid matching set on lane 0.
REQ-016 SHALL have port upconfigure_capability, output, 1: bit [42] from that same set.

Function
REQ-017 SHALL decode ordered-set fields as follows: link = [15:8], lane = [23:16], identifier = [87:80], PAD = 8'hF7, TS1 = 8'h2A, TS2 = 8'h45.
REQ-018 SHALL define the match predicate per substate:
- pollingActive: link=PAD, lane=PAD, and either TS1 with bit43=0, TS1 with bit42=1, or TS2.
- pollingConfiguration: link=PAD, lane=PAD, TS2.
- configurationLinkWidthStart: TS1, lane=PAD; link=linkNumber (DEVICETYPE 0) or link!=PAD (DEVICETYPE 1).
- configurationLinkWidthAccept: TS1, link=linkNumber, lane!=PAD.
- configurationLanenumWait and configurationLanenumAccept: link=linkNumber, lane=expected lane number; TS1 when DEVICETYPE=0, TS2 when DEVICETYPE=1.
- configurationComplete: TS2, link=linkNumber, lane=expected lane number.
- Any other substate: never matches.
REQ-019 SHALL give each lane its own state machine with states IDLE, HUNT, COUNT and DONE.
REQ-020 SHALL make IDLE go to HUNT in the cycle after substate holds a code with a defined predicate.
REQ-021 SHALL make HUNT load count=1 and go to COUNT on a valid matching set, and hold otherwise.
REQ-022 SHALL, in COUNT, increment count on a valid matching set, go back to HUNT with count=0 on a valid non-matching set, and hold while valid=0.
REQ-023 SHALL enter DONE in the same edge at which count reaches THRESH.
REQ-024 SHALL keep DONE and the count saturated at THRESH; a valid non-matching set in DONE SHALL NOT clear it.
REQ-025 SHALL, on any change of substate, force every lane to IDLE with count=0 on the next edge; this overrides a match arriving in the same cycle.
REQ-026 SHALL register laneCount, laneDone and allDone, so they reflect a set one cycle after its valid.
REQ-027 SHALL hold rateid and upconfigure_capability when lane 0 has valid=0.

Reset
REQ-028 SHALL, on reset low, immediately put all lanes in IDLE with laneCount=0, laneDone=0, allDone=0, rateid=8'h00 and upconfigure_capability=0.
REQ-029 SHALL resume operation on the first rising edge after reset is released.

Configuration
REQ-030 SHALL, with TS_CONSIST_CHK_EN defined, send a lane in COUNT back to HUNT with count=1 when, in configurationComplete, a valid matching set has a different [39:32] or bit [42] from that lane's previous valid set.
REQ-031 SHALL, without TS_CONSIST_CHK_EN, not perform the consistency comparison and not include the per-lane previous-set registers.

Structure
REQ-032 SHALL take the substate codes, the PAD/TS1/TS2 constants, the field bit positions and the lane state enum from shared package ltssm_pkg.
REQ-033 SHALL implement one lane as sub-module ts_lane_checker and instantiate it LANES times through a generate loop.

Verification
REQ-034 SHALL cover: pollingActive, LANES=4, THRESH=8, 8 consecutive valid PAD/PAD/TS1 (bit43=0) sets on all lanes -> laneDone=4'hF and allDone=1 one cycle after the 8th set.
REQ-035 SHALL cover: configurationLanenumWait, DEVICETYPE=0, linkNumber=8'h05, laneBase=8'h02, lane 3 receives lane byte 8'h04 -> lane 3 never counts, lanes 0-2 reach THRESH, allDone=0.
REQ-036 SHALL cover: 5 matches followed by 1 mismatch followed by 8 matches -> count sequence 1..5, 0, 1..8, with laneDone=1 after the final set.
REQ-037 SHALL cover: substate changes while count=6 with a simultaneous match -> count=0, lane in IDLE, then HUNT.
REQ-038 SHALL cover: with TS_CONSIST_CHK_EN, in configurationComplete, rate id 8'h02 on sets 1-3 then 8'h04 on set 4 -> count=1 after set 4; without the macro, count=4.
REQ-039 SHALL cover: reset asserted mid-COUNT, asynchronous to clk -> all outputs return to their REQ-028 values before the next clk edge.
